// File: rtl/ifm_acc_pkg.sv
// ifm_acc_pkg: shared conv-accelerator types; IFM_HPAD_EN enables horizontal zero padding
package ifm_acc_pkg;
  localparam int DATA_W = 8;
  localparam int KSIZE = 3;
`ifdef IFM_HPAD_EN
  localparam int HPAD = 1;
`else
  localparam int HPAD = 0;
`endif
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  typedef logic signed [DATA_W-1:0] pixel_t;
  typedef struct packed {
    logic v;
    logic rd;
    logic win;
    logic [1:0] kr;
  } slot_t;
endpackage

// File: rtl/ifm_addr_gen.sv
// ifm_addr_gen: column/kernel-row/output-row counters and row_base adder for the IFM walk
module ifm_addr_gen
  import ifm_acc_pkg::*;
#(
  parameter int IFM_W = 32,
  parameter int IFM_H = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        kr,
  output logic              rd,
  output logic              win,
  output logic              last_job
);
  localparam int COLS = IFM_W + 2 * HPAD;
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(IFM_H);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IFM_H - 3);
  localparam logic [1:0] KR_LAST = 2'(KSIZE - 1);
  logic [CW-1:0] col_q, col_d;
  logic [1:0] kr_q, kr_d;
  logic [RW-1:0] row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic wrap, next_row;
  always_comb begin
    wrap = inc && col_q == COL_LAST;
    next_row = wrap && kr_q == KR_LAST;
    col_d = (clr || wrap) ? '0 : inc ? col_q + CW'(1) : col_q;
    kr_d = (clr || next_row) ? '0 : wrap ? kr_q + 2'd1 : kr_q;
    row_d = clr ? '0 : (next_row && row_q != ROW_LAST) ? row_q + RW'(1) : row_q;
    base_d = clr ? '0 : next_row ? base_q - ADDR_W'(IFM_W) : wrap ? base_q + ADDR_W'(IFM_W) : base_q;
    addr = base_q + ADDR_W'(col_q) - ADDR_W'(HPAD);
    kr = kr_q;
    rd = (col_q - CW'(HPAD)) < CW'(IFM_W);
    win = col_q >= CW'(2);
    last_job = col_q == COL_LAST && kr_q == KR_LAST && row_q == ROW_LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      kr_q <= '0;
      row_q <= '0;
      base_q <= '0;
    end else begin
      col_q <= col_d;
      kr_q <= kr_d;
      row_q <= row_d;
      base_q <= base_d;
    end
  end
endmodule

// File: rtl/ifm_fetch_ctrl.sv
// ifm_fetch_ctrl: 3x3-conv IFM row streamer feeding the shift buffer; IFM_HPAD_EN adds horizontal zero padding
module ifm_fetch_ctrl
  import ifm_acc_pkg::*;
#(
  parameter int IFM_W = 32,
  parameter int IFM_H = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic signed [7:0] mem_rdata,
  output logic signed [7:0] ifm_input,
  output logic              ifm_read,
  output logic              win_valid,
  output logic [1:0]        kr,
  output logic              busy,
  output logic              done
);
  state_t state_q, state_d;
  slot_t s1_q, s1_d;
  pixel_t ifm_input_q, ifm_input_d;
  logic ifm_read_q, ifm_read_d, win2_q, win2_d, win_valid_q, win_valid_d;
  logic [1:0] kr2_q, kr2_d, kr_q, kr_d;
  logic issue, clr, drained, last_job, slot_rd, slot_win;
  logic [1:0] slot_kr;
  logic [ADDR_W-1:0] addr;

  ifm_addr_gen #(.IFM_W(IFM_W), .IFM_H(IFM_H), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(issue),
    .addr(addr),
    .kr(slot_kr),
    .rd(slot_rd),
    .win(slot_win),
    .last_job(last_job)
  );

  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end

  always_comb begin
    state_d = (state_q == IDLE) ? (start ? FETCH : IDLE) :
              (state_q == FETCH) ? ((issue && last_job) ? DRAIN : FETCH) :
              (state_q == DRAIN) ? (drained ? DONE : DRAIN) : IDLE;
  end

  always_comb begin
    issue = state_q == FETCH && !pause;
    clr = state_q == IDLE;
    mem_en = issue && slot_rd;
    mem_addr = mem_en ? addr : '0;
    busy = state_q == FETCH || state_q == DRAIN;
    done = state_q == DONE;
    drained = !s1_q.v && !ifm_read_q && !win2_q;
    ifm_input = ifm_input_q;
    ifm_read = ifm_read_q;
    win_valid = win_valid_q;
    kr = kr_q;
  end

  // pad slots travel the same 2-cycle pipe as real reads but deliver zero
  always_comb begin
    s1_d = '{v: issue, rd: mem_en, win: slot_win, kr: slot_kr};
    ifm_read_d = s1_q.v;
    ifm_input_d = s1_q.rd ? mem_rdata : '0;
    win2_d = s1_q.v && s1_q.win;
    kr2_d = s1_q.kr;
    win_valid_d = win2_q;
    kr_d = win2_q ? kr2_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      ifm_read_q <= 1'b0;
      ifm_input_q <= '0;
      win2_q <= 1'b0;
      kr2_q <= '0;
      win_valid_q <= 1'b0;
      kr_q <= '0;
    end else begin
      s1_q <= s1_d;
      ifm_read_q <= ifm_read_d;
      ifm_input_q <= ifm_input_d;
      win2_q <= win2_d;
      kr2_q <= kr2_d;
      win_valid_q <= win_valid_d;
      kr_q <= kr_d;
    end
  end
endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// tb_ifm_fetch_ctrl: scoreboard bench for ifm_fetch_ctrl (IFM_HPAD_EN selects the padded 4x3 job)
module tb_ifm_fetch_ctrl;
`ifdef IFM_HPAD_EN
  localparam int W = 4, H = 3, HP = 1;
`else
  localparam int W = 4, H = 4, HP = 0;
`endif
  localparam int AW = 10;
  localparam int READS = (H - 2) * 3 * W;
  localparam int SLOTS = (H - 2) * 3 * (W + 2 * HP);
  localparam int WINS = (H - 2) * 3 * (W + 2 * HP - 2);

  typedef struct packed {
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] b0;
    logic [1:0] k;
  } win_t;

  logic clk = 1'b0;
  logic rst, start, pause;
  logic mem_en;
  logic [AW-1:0] mem_addr;
  logic signed [7:0] mem_rdata, ifm_input;
  logic ifm_read, win_valid, busy, done;
  logic [1:0] kr;

  logic [AW-1:0] exp_addr[$];
  logic [7:0] exp_pix[$];
  win_t exp_win[$];
  int tests, fails, cyc, en_count, rd_count, win_count, done_count, last_win_cyc, done_cyc;
  logic en_d1, en_d2;
  logic [7:0] b0, b1, b2, p;
  logic [AW-1:0] a;
  win_t w;
  bit mon_on;

  always #5 clk = ~clk;

  ifm_fetch_ctrl #(.IFM_W(W), .IFM_H(H), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pause(pause),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .ifm_input(ifm_input),
    .ifm_read(ifm_read),
    .win_valid(win_valid),
    .kr(kr),
    .busy(busy),
    .done(done)
  );

  always @(posedge clk) mem_rdata <= mem_en ? mem_addr[7:0] : 8'h5a;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (win_valid) begin
        win_count++;
        last_win_cyc = cyc;
        tests++;
        if (exp_win.size() == 0) begin
          fails++;
          $display("FAIL win_extra: got window %0d,%0d,%0d kr=%0d, required none", b2, b1, b0, kr);
        end else begin
          w = exp_win.pop_front();
          if ({b2, b1, b0, kr} !== w) begin
            fails++;
            $display("FAIL window: got %0d,%0d,%0d kr=%0d, required %0d,%0d,%0d kr=%0d", b2, b1, b0, kr, w.b2, w.b1, w.b0, w.k);
          end
        end
      end
      if (ifm_read) begin
        rd_count++;
        tests++;
        if (exp_pix.size() == 0) begin
          fails++;
          $display("FAIL pix_extra: got %0d, required none", ifm_input);
        end else begin
          p = exp_pix.pop_front();
          if (ifm_input !== p) begin
            fails++;
            $display("FAIL pixel: got %0d, required %0d", ifm_input, p);
          end
        end
`ifndef IFM_HPAD_EN
        tests++;
        if (en_d2 !== 1'b1) begin
          fails++;
          $display("FAIL read_latency: mem_en two cycles earlier was %b, required 1", en_d2);
        end
`endif
        b2 = b1;
        b1 = b0;
        b0 = ifm_input;
      end
      if (mem_en) begin
        en_count++;
        tests++;
        if (exp_addr.size() == 0) begin
          fails++;
          $display("FAIL addr_extra: got %0d, required none", mem_addr);
        end else begin
          a = exp_addr.pop_front();
          if (mem_addr !== a) begin
            fails++;
            $display("FAIL addr: got %0d, required %0d", mem_addr, a);
          end
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
    en_d2 = en_d1;
    en_d1 = mem_en;
  end

  task automatic build_expected;
    logic [7:0] row_px[$];
    exp_addr.delete();
    exp_pix.delete();
    exp_win.delete();
    for (int r = 0; r <= H - 3; r++)
      for (int k = 0; k < 3; k++) begin
        row_px.delete();
`ifdef IFM_HPAD_EN
        row_px.push_back(8'd0);
`endif
        for (int c = 0; c < W; c++) begin
          exp_addr.push_back(AW'((r + k) * W + c));
          row_px.push_back(8'((r + k) * W + c));
        end
`ifdef IFM_HPAD_EN
        row_px.push_back(8'd0);
`endif
        foreach (row_px[i]) exp_pix.push_back(row_px[i]);
        for (int i = 2; i < row_px.size(); i++)
          exp_win.push_back({row_px[i-2], row_px[i-1], row_px[i], 2'(k)});
      end
    en_count = 0;
    rd_count = 0;
    win_count = 0;
    done_count = 0;
    last_win_cyc = -100;
    done_cyc = -1;
    b0 = 0;
    b1 = 0;
    b2 = 0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1 ok = done;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", budget);
    end
  endtask

  task automatic check_totals(input string nm);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (en_count !== READS) begin fails++; $display("FAIL %s mem_en_count: got %0d, required %0d", nm, en_count, READS); end
    tests++;
    if (rd_count !== SLOTS) begin fails++; $display("FAIL %s ifm_read_count: got %0d, required %0d", nm, rd_count, SLOTS); end
    tests++;
    if (win_count !== WINS) begin fails++; $display("FAIL %s win_count: got %0d, required %0d", nm, win_count, WINS); end
    tests++;
    if (done_count !== 1) begin fails++; $display("FAIL %s done_count: got %0d, required 1", nm, done_count); end
    tests++;
    if (done_cyc !== last_win_cyc + 1) begin fails++; $display("FAIL %s done_timing: got cycle %0d, required %0d", nm, done_cyc, last_win_cyc + 1); end
    tests++;
    if (exp_addr.size() + exp_pix.size() + exp_win.size() != 0) begin
      fails++;
      $display("FAIL %s leftovers: got %0d expected items undelivered, required 0", nm, exp_addr.size() + exp_pix.size() + exp_win.size());
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL %s busy_after: got %b, required 0", nm, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b0;
    tests++;
    if ({mem_en, mem_addr, ifm_input, ifm_read, win_valid, kr} !== '0) begin
      fails++;
      $display("FAIL reset_data: got en=%b addr=%0d in=%0d rd=%b wv=%b kr=%0d, required all 0", mem_en, mem_addr, ifm_input, ifm_read, win_valid, kr);
    end
    tests++;
    if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_ctrl: got busy=%b done=%b, required 0 0", busy, done); end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_start: got busy=%b, required 0", busy); end
  endtask

  task automatic test_basic;
    build_expected();
    pulse_start();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_rise: got %b, required 1", busy); end
    wait_done(400);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_in_done: got %b, required 0", busy); end
    check_totals("basic");
  endtask

  task automatic test_pause;
    int e0, r0;
    bit seen = 0;
    build_expected();
    pulse_start();
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1 seen = en_count >= 5;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL pause_wait: got %0d reads, required 5", en_count); end
    pause = 1'b1;
    e0 = en_count;
    r0 = rd_count;
    repeat (3) @(posedge clk);
    #1 pause = 1'b0;
    tests++;
    if (en_count !== e0) begin fails++; $display("FAIL pause_reads: got %0d new reads while paused, required 0", en_count - e0); end
    tests++;
    if (rd_count <= r0) begin fails++; $display("FAIL pause_inflight: got %0d deliveries while paused, required >0", rd_count - r0); end
    wait_done(400);
    check_totals("pause");
  endtask

  task automatic test_midreset;
    bit seen = 0;
    build_expected();
    pulse_start();
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1 seen = en_count >= 7;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    tests++;
    if ({mem_en, mem_addr, ifm_input, ifm_read, win_valid, kr, busy, done} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got en=%b addr=%0d rd=%b wv=%b busy=%b done=%b, required all 0", mem_en, mem_addr, ifm_read, win_valid, busy, done);
    end
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (ifm_read !== 1'b0 || win_valid !== 1'b0) begin fails++; $display("FAIL midreset_flush: got rd=%b wv=%b, required 0 0", ifm_read, win_valid); end
    build_expected();
    pulse_start();
    wait_done(400);
    check_totals("restart");
  endtask

  task automatic test_start_ignored;
    build_expected();
    pulse_start();
    repeat (4) @(posedge clk);
    #1 pulse_start();
    wait_done(400);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (done_count !== 1) begin fails++; $display("FAIL extra_done: got %0d, required 1", done_count); end
    tests++;
    if (en_count !== READS || busy !== 1'b0) begin fails++; $display("FAIL second_job: got %0d reads busy=%b, required %0d busy=0", en_count, busy, READS); end
    build_expected();
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || en_count !== 0 || done_count !== 0) begin
      fails++;
      $display("FAIL rst_start_job: got busy=%b reads=%0d done=%0d, required 0 0 0", busy, en_count, done_count);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    mon_on = 0;
    test_reset();
    mon_on = 1;
    test_basic();
    test_pause();
    test_midreset();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
